mux_n_pipe_stage: RTL and testbench

- Parametrised N:1 word multiplexer followed by a registered output stage with a valid/ready handshake and a 2-entry skid buffer.
- Generalises the fixed 2:1 and 3:1 datapath muxes in width and input count.
- Adds backpressure, flush and out-of-range select reporting.
- Sits between pipeline stages wherever a selected operand or PC source must be registered, e.g. PC source select feeding the fetch stage, or forwarding select feeding EX.

---
 rtl/datapath_pkg.sv | 29 ++
 rtl/mux_n_comb.sv | 27 ++
 rtl/mux_n_pipe_stage.sv | 129 ++++++++++++
 tb/tb_mux_n_pipe_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: word width, named mux select encodings and the
// occupancy states used by registered pipeline stages.
package datapath_pkg;

  localparam int unsigned WORD_W = 32;

  // PC-source select encodings.
  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;

  // Operand forwarding select encodings.
  localparam logic [1:0] SEL_FWD_RF  = 2'd0;
  localparam logic [1:0] SEL_FWD_EX  = 2'd1;
  localparam logic [1:0] SEL_FWD_MEM = 2'd2;

  // Number of beats held by a stage with a main register and one skid register.
  typedef enum logic [1:0] {
    StEmpty,
    StFull1,
    StFull2
  } occ_e;

  // True when a binary select addresses an existing input.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
    return sel < num_in;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 word mux. An out-of-range select yields an all-zero word
// and raises err_o.
module mux_n_comb
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        word_o,
  output logic                    err_o
);

  // Pick the addressed word; nothing matches when sel_i is out of range.
  always_comb begin
    word_o = '0;
    err_o  = !sel_in_range(32'(sel_i), NUM_IN);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        word_o = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe_stage.sv
// N:1 mux followed by a registered valid/ready output stage with a one-entry
// skid register. in_ready depends only on registered occupancy, so there is no
// combinational path from out_ready or any input to any output.
module mux_n_pipe_stage
  import datapath_pkg::*;
#(
  parameter int unsigned     WIDTH     = WORD_W,
  parameter int unsigned     NUM_IN    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned    SEL_W     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic             acc_beat;
  logic             rel_beat;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data_i (in_data),
    .sel_i  (sel),
    .word_o (mux_word),
    .err_o  (mux_err)
  );

  assign acc_beat = in_valid && in_ready;
  assign rel_beat = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state; flush empties the stage regardless of traffic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (acc_beat) state_d = StFull1;
      StFull1: begin
        if (acc_beat && !rel_beat) begin
          state_d = StFull2;
        end else if (!acc_beat && rel_beat) begin
          state_d = StEmpty;
        end
      end
      StFull2: if (rel_beat) state_d = StFull1;
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  // Handshake outputs decoded from registered occupancy only.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StFull2);
  end

  // Datapath next state: skid refills main on release; otherwise a new beat
  // lands in main when it is free (or freeing) and in skid when it is not.
  always_comb begin
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    if (flush) begin
      main_data_d = RESET_VAL;
      main_err_d  = 1'b0;
    end else if (state_q == StFull2) begin
      if (rel_beat) begin
        main_data_d = skid_data_q;
        main_err_d  = skid_err_q;
      end
    end else if (acc_beat) begin
      if (state_q == StEmpty || rel_beat) begin
        main_data_d = mux_word;
        main_err_d  = mux_err;
      end else begin
        skid_data_d = mux_word;
        skid_err_d  = mux_err;
      end
    end
  end

  // Main and skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q <= RESET_VAL;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_data = main_data_q;
  assign out_err  = main_err_q;

endmodule

// File: tb/tb_mux_n_pipe_stage.sv
// Bench for mux_n_pipe_stage (NUM_IN=3, WIDTH=32). The reference model is a
// two-deep FIFO of {err, word} entries: the head is what the stage presents.
module tb_mux_n_pipe_stage;
  import datapath_pkg::*;

  localparam logic [31:0] RST_VAL = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] q[$];
  bit          clean;

  mux_n_pipe_stage #(
    .WIDTH     (32),
    .NUM_IN    (3),
    .RESET_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the FIFO model at the edge, then compare.
  task automatic step(input bit r, input bit f, input bit v, input logic [1:0] s,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input bit ordy);
    bit          acc;
    bit          rel;
    logic [31:0] w;
    logic        e;
    rst       = r;
    flush     = f;
    in_valid  = v;
    sel       = s;
    in_data   = {d2, d1, d0};
    out_ready = ordy;
    e   = (s > 2'd2);
    w   = (s == 2'd0) ? d0 : (s == 2'd1) ? d1 : (s == 2'd2) ? d2 : 32'h0;
    acc = v && (q.size() < 2);
    rel = (q.size() > 0) && ordy;
    @(posedge clk);
    if (r || f) begin
      q.delete();
      clean = 1'b1;
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) begin
        q.push_back({e, w});
        clean = 1'b0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][31:0]);
      chk("out_err", 32'(out_err), 32'(q[0][32]));
    end else if (clean) begin
      chk("out_data_rst", out_data, RST_VAL);
      chk("out_err_rst", 32'(out_err), 32'h0);
    end
  endtask

  localparam logic [31:0] D0 = 32'h11111111;
  localparam logic [31:0] D1 = 32'h22222222;
  localparam logic [31:0] D2 = 32'h33333333;

  initial begin
    clean     = 1'b1;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    sel       = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset
    step(1, 0, 0, 0, D0, D1, D2, 0);
    step(1, 0, 0, 0, D0, D1, D2, 0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    // Pass-through: sel=1
    step(0, 0, 1, SEL_BR, D0, D1, D2, 1);
    chk("pass_data", out_data, 32'h22222222);
    chk("pass_err", 32'(out_err), 32'h0);

    // Out-of-range then in-range
    step(0, 0, 1, 2'd3, D0, D1, D2, 1);
    chk("oor_data", out_data, 32'h0);
    chk("oor_err", 32'(out_err), 32'h1);
    step(0, 0, 1, SEL_PC4, D0, D1, D2, 1);
    chk("after_oor_data", out_data, 32'h11111111);
    step(0, 0, 0, 0, D0, D1, D2, 1);

    // Backpressure: A to main, B to skid, then drain
    step(0, 0, 1, SEL_FWD_RF, 32'hA, 32'h0, 32'h0, 0);
    step(0, 0, 1, SEL_FWD_RF, 32'hB, 32'h0, 32'h0, 0);
    chk("skid_full_in_ready", 32'(in_ready), 32'h0);
    step(0, 0, 1, SEL_FWD_RF, 32'hC, 32'h0, 32'h0, 0);
    chk("hold_data", out_data, 32'hA);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    chk("drain_b", out_data, 32'hB);
    chk("drain_in_ready", 32'(in_ready), 32'h1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    chk("drained_valid", 32'(out_valid), 32'h0);

    // Streaming: 16 beats, sel cycling 0..2
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 2'(i % 3), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 1);
    end
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);

    // Flush with main+skid full and a beat offered
    step(0, 0, 1, SEL_FWD_EX, 32'h0, 32'hF1, 32'h0, 0);
    step(0, 0, 1, SEL_FWD_MEM, 32'h0, 32'h0, 32'hF2, 0);
    step(0, 1, 1, SEL_JMP, 32'h0, 32'h0, 32'hF3, 0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_data", out_data, RST_VAL);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);

    // Reset while full, with flush also high
    step(0, 0, 1, 2'd0, 32'hE1, 32'h0, 32'h0, 0);
    step(0, 0, 1, 2'd0, 32'hE2, 32'h0, 32'h0, 0);
    step(1, 1, 1, 2'd0, 32'hE3, 32'h0, 32'h0, 1);
    chk("rst_full_valid", 32'(out_valid), 32'h0);
    chk("rst_full_data", out_data, RST_VAL);
    step(0, 0, 1, 2'd1, 32'h0, 32'hE4, 32'h0, 1);
    chk("post_rst_accept", out_data, 32'hE4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
